pipeline_ctrl: RTL
==================

# pipeline_ctrl

Central stall/flush sequencer for the 5-stage core. Combines the decode-stage load-use request, execute-stage redirects, data-memory back-pressure and multi-cycle execute operations (div, fdiv, fsqrt) into per-stage stall/flush controls. It also issues the start pulse to the multi-cycle unit and keeps stall/flush performance counters. The block sits beside the forwarding/hazard logic; its outputs drive the F/D/E/M pipeline register enables and clears.

## Interface
- MC_TIMEOUT, 64: maximum cycles spent in MC_WAIT before forced release (≥2).
- CNT_W, 32: width of the performance counters.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- lwstall  in  1  load-use hazard on the instruction in D.
- redirectE  in  1  control transfer in E resolves non-sequential.
- mcopE  in  1  instruction in E is a multi-cycle op.
- mc_done  in  1  multi-cycle unit result valid (1-cycle pulse).
- mem_busy  in  1  data memory not ready for the instruction in M.
- stallF, stallD, stallE, stallM  out  1 each  hold the corresponding pipeline register.
- flushD, flushE, flushM  out  1 each  load a bubble into the corresponding register.
- mc_start  out  1  launch the multi-cycle unit (1-cycle pulse).
- mc_busy  out  1  state == MC_WAIT.
- mc_timeout_err  out  1  sticky: a multi-cycle op timed out.
- stall_cycles  out  CNT_W  cycles with stallF=1.
- flush_count  out  CNT_W  redirect events taken.

## Operation
- States: RUN, MC_WAIT. Reset state is RUN. mc_wait_cnt = 0, counters = 0, mc_timeout_err = 0.
- While rst=1, all stall/flush/mc_start outputs are forced to 0.
- Stall/flush/mc_start outputs are Mealy: combinational from state and current inputs.
- RUN, evaluated in strict priority order:
  1. mem_busy=1: stallF/D/E/M=1, no flush, mc_start=0. Stay in RUN. Any pending mcopE waits.
  2. mcopE=1: mc_start=1, stallF/D/E=1, flushM=1. Next state MC_WAIT, mc_wait_cnt←0.
  3. redirectE=1: flushD=1, flushE=1, no stall. flush_count+1. Redirect beats lwstall because the D instruction is wrong-path.
  4. lwstall=1: stallF=1, stallD=1, flushE=1.
  5. Otherwise all outputs 0.
- MC_WAIT:
  - mem_busy, lwstall and redirectE are ignored.
  - mc_done=0 and mc_wait_cnt < MC_TIMEOUT-1: stallF/D/E=1, flushM=1, mc_wait_cnt+1.
  - mc_done=1: all outputs 0, so the E result advances to M. Next state RUN.
  - mc_done=0 and mc_wait_cnt == MC_TIMEOUT-1: same outputs and transition as mc_done=1, plus mc_timeout_err←1.
- mc_done outside MC_WAIT is ignored.
- mc_timeout_err is cleared only by rst.
- Counters wrap modulo 2^CNT_W; they do not saturate.
- stall_cycles increments on every non-reset cycle with stallF=1, in either state.
- Reset asserted mid-MC_WAIT: the next state is RUN with no mc_start. The multi-cycle unit is reset by the same rst.

## Timing
- Control outputs: zero-cycle latency from inputs.
- mc_busy, mc_timeout_err, counters: registered, updated at the edge following the causing cycle.
- mc_start asserted in cycle N:
  - mc_done is accepted from N+1 onward.
  - If mc_done arrives at N+L, E is stalled cycles N..N+L-1 (L cycles).
  - The op enters M at the end of cycle N+L.
  - mc_busy=1 for cycles N+1..N+L.
- mc_start never asserts in two consecutive cycles.
- mc_start never asserts while mem_busy=1.
- Worst-case MC_WAIT residency: MC_TIMEOUT cycles.

## Test plan
- Reset: hold rst 2 cycles with every input =1 -> all control outputs 0. After release: state RUN, counters 0, mc_timeout_err 0.
- Load-use: lwstall=1 for one cycle -> stallF=stallD=flushE=1 that cycle only; stall_cycles=1.
- Simultaneous redirectE=1 and lwstall=1 -> flushD=flushE=1, stallF=stallD=0; flush_count=1, stall_cycles=0.
- Multi-cycle: mcopE=1 from cycle 0, mc_done at cycle 5.
  - mc_start only in cycle 0.
  - stallF/D/E and flushM =1 in cycles 0-4; all 0 in cycle 5.
  - mc_busy =1 in cycles 1-5.
  - stall_cycles=5.
- Memory back-pressure: mem_busy=1 for cycles 0-2 with mcopE=1 from cycle 0.
  - All four stalls =1 in cycles 0-2, mc_start=0.
  - mc_start=1 in cycle 3.
- Timeout and wrap, with MC_TIMEOUT=4, CNT_W=4:
  - mcopE=1 at cycle 0, no mc_done -> stalls in cycles 0-3, released in cycle 4; mc_timeout_err=1 from cycle 5 and stays set until rst.
  - 17 lwstall cycles -> stall_cycles wraps to 1.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//
// Central stall/flush sequencer for the 5-stage core. It merges the load-use
// request from D, redirects resolved in E, data-memory back-pressure in M and
// multi-cycle execute operations (div/fdiv/fsqrt) into per-stage hold and
// bubble controls. It also issues the start pulse to the multi-cycle unit and
// keeps stall/flush performance counters.
//
// Parameters
//   MC_TIMEOUT  maximum cycles spent waiting for mc_done (>= 2)
//   CNT_W       width of the performance counters
//
// Ports
//   clk                      clock, all state updates on the rising edge
//   rst                      synchronous reset, active-high
//   lwstall                  load-use hazard on the instruction in D
//   redirectE                control transfer in E resolves non-sequential
//   mcopE                    instruction in E is a multi-cycle op
//   mc_done                  multi-cycle result valid (1-cycle pulse)
//   mem_busy                 data memory not ready for the instruction in M
//   stallF/D/E/M             hold the corresponding pipeline register
//   flushD/E/M               load a bubble into the corresponding register
//   mc_start                 launch the multi-cycle unit (1-cycle pulse)
//   mc_busy                  waiting on the multi-cycle unit
//   mc_timeout_err           sticky: a multi-cycle op timed out
//   stall_cycles             cycles with stallF=1 (wrapping)
//   flush_count              redirect events taken (wrapping)
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lwstall,
    input  logic             redirectE,
    input  logic             mcopE,
    input  logic             mc_done,
    input  logic             mem_busy,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             mc_start,
    output logic             mc_busy,
    output logic             mc_timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int             WCW      = $clog2(MC_TIMEOUT);
    localparam logic [WCW-1:0] LAST_CNT = WCW'(MC_TIMEOUT - 1);

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             redirect_taken;

    // Next-state and Mealy control outputs. While rst is high everything
    // stays at its default of 0; the register block performs the reset.
    always_comb begin
        stallF         = 1'b0;
        stallD         = 1'b0;
        stallE         = 1'b0;
        stallM         = 1'b0;
        flushD         = 1'b0;
        flushE         = 1'b0;
        flushM         = 1'b0;
        mc_start       = 1'b0;
        redirect_taken = 1'b0;
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        err_d          = err_q;

        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (mem_busy) begin
                        // Whole pipe frozen; a pending multi-cycle op in E
                        // simply waits and launches once memory is ready.
                        stallF = 1'b1;
                        stallD = 1'b1;
                        stallE = 1'b1;
                        stallM = 1'b1;
                    end else if (mcopE) begin
                        // Hold F/D/E and keep a bubble flowing into M while
                        // the unit works.
                        mc_start   = 1'b1;
                        stallF     = 1'b1;
                        stallD     = 1'b1;
                        stallE     = 1'b1;
                        flushM     = 1'b1;
                        state_d    = MC_WAIT;
                        wait_cnt_d = '0;
                    end else if (redirectE) begin
                        // The D instruction is wrong-path, so a redirect
                        // overrides any load-use request against it.
                        flushD         = 1'b1;
                        flushE         = 1'b1;
                        redirect_taken = 1'b1;
                    end else if (lwstall) begin
                        stallF = 1'b1;
                        stallD = 1'b1;
                        flushE = 1'b1;
                    end
                end

                MC_WAIT: begin
                    if (mc_done || (wait_cnt_q == LAST_CNT)) begin
                        // Release: outputs stay 0 so the E result moves on.
                        state_d = RUN;
                        if (!mc_done) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        stallF     = 1'b1;
                        stallD     = 1'b1;
                        stallE     = 1'b1;
                        flushM     = 1'b1;
                        wait_cnt_d = wait_cnt_q + WCW'(1);
                    end
                end

                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // Performance counters wrap naturally at 2^CNT_W.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stallF) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (redirect_taken) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mc_busy        = (state_q == MC_WAIT);
    assign mc_timeout_err = err_q;
    assign stall_cycles   = stall_cnt_q;
    assign flush_count    = flush_cnt_q;

endmodule
